conv_layer_sequencer: RTL
=========================

Name: conv_layer_sequencer

Overview:
Sequences one convolution layer over the single-channel 5x5 conv engine.
- For every (output channel, input channel) pair it loads 25 weights from the weight ROM into a held register bank, pulses the engine's start, streams one MAPSIZE x MAPSIZE input plane from feature-map BRAM, and waits for the engine's all_done.
- It exports channel indices and a first-input-channel flag so that a downstream accumulator can choose between overwrite and accumulate.
- It sits between the layer-level control/host and the conv engine plus its memories.

Parameters:
MAPSIZE, 32, input plane width/height in pixels; must match the engine.
IN_CH, 6, number of input channels (>=1).
OUT_CH, 16, number of output channels (>=1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
layer_start  in  1  starts the layer; only accepted in IDLE
layer_busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse when the layer completes
wt_rd_addr  out  $clog2(OUT_CH*IN_CH*25)  weight ROM address; data is valid 1 cycle later
wt_rd_data  in  8 signed  weight ROM data
weights  out  [4:0][4:0] x 8 signed  held weight bank, wired to the engine
fm_rd_en  out  1  feature BRAM read enable
fm_rd_addr  out  $clog2(IN_CH*MAPSIZE*MAPSIZE)  feature BRAM address; data is valid 1 cycle later
fm_rd_data  in  8 signed  feature BRAM data
eng_start  out  1  one-cycle start pulse to the engine
eng_data_valid  out  1  qualifies eng_pixel
eng_pixel  out  8 signed  equals fm_rd_data (pass-through)
eng_all_done  in  1  one-cycle completion pulse from the engine
oc_idx  out  $clog2(OUT_CH) (min 1)  current output channel
ic_idx  out  $clog2(IN_CH) (min 1)  current input channel
first_ic  out  1  high while ic_idx==0 (accumulator overwrite mode)

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0, the weights bank is cleared, and the FSM enters IDLE. Reset mid-layer aborts with no layer_done pulse. The engine must share the same rst.
- States and transitions:
  - IDLE -> LOAD_W on layer_start. Entering LOAD_W clears oc_idx and ic_idx.
  - LOAD_W -> START.
  - START -> STREAM.
  - STREAM -> WAIT_DONE.
  - WAIT_DONE -> NEXT.
  - NEXT -> LOAD_W, or NEXT -> DONE after the last channel pair.
  - DONE -> IDLE.
- LOAD_W:
  - Issues addresses base..base+24 on consecutive cycles, where base = (oc_idx*IN_CH + ic_idx)*25.
  - Tap k = r*5 + c is written into weights[r][c] one cycle after its address is issued.
  - Takes 26 cycles. The bank changes only in LOAD_W.
- START: eng_start=1 for exactly one cycle.
- STREAM:
  - Asserts fm_rd_en for MAPSIZE*MAPSIZE consecutive cycles, with addresses ic_idx*MAPSIZE^2 + p for p = 0..MAPSIZE^2-1 in raster order.
  - eng_data_valid is fm_rd_en delayed by 1 register, so it forms an unbroken burst of MAPSIZE^2 cycles.
  - Leaves STREAM on the cycle after the last valid pixel.
- WAIT_DONE:
  - Holds weights stable while the engine flushes.
  - Leaves when eng_all_done==1. There is no timeout.
  - eng_all_done is ignored in every other state.
- NEXT:
  - If ic_idx < IN_CH-1, then ic_idx++.
  - Otherwise ic_idx=0; if oc_idx < OUT_CH-1, then oc_idx++, else go to DONE.
  - Iteration order: output channel outer, input channel inner.
- DONE: layer_done=1 for one cycle, then IDLE.
- layer_start is ignored while busy.
- IN_CH=1 and/or OUT_CH=1 must work: first_ic stays high throughout when IN_CH=1.
- Per-pair overhead excluding engine flush: LOAD_W 26 + START 1 + STREAM MAPSIZE^2 + 1 valid-delay cycle + NEXT 1.

Optional Feature:
CONV_SEQ_PERF_EN
- Defined:
  - Adds output layer_cycles (32 bits).
  - The count is cleared on the layer_start accept cycle and increments every cycle while busy.
  - Saturates at 0xFFFFFFFF and holds its value after layer_done until the next start.
  - Reset value is 0.
- Undefined: the port and counter are absent, with no other behaviour change.

Decomposition:
- Package conv_pkg:
  - seq_state_t enum {IDLE, LOAD_W, START, STREAM, WAIT_DONE, NEXT, DONE}.
  - KWIN=5, KTAPS=25.
  - The weight-window typedef shared with the engine.
- Sub-module conv_weight_loader:
  - Handles the 25-address issue, the 1-cycle-latency capture into the bank, and a done pulse.
  - The sequencer FSM instantiates it.

Test Plan:
1. MAPSIZE=8, IN_CH=1, OUT_CH=1, ROM tap k = k, engine model that asserts done 10 cycles after its last valid. Pulse layer_start -> weights[4][4]==24 before eng_start; exactly 64 eng_data_valid cycles over addresses 0..63; one layer_done pulse; layer_busy low afterwards.
2. IN_CH=3, OUT_CH=2 -> (oc,ic) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); first_ic high only for ic=0; weight bases 0,25,50,75,100,125; feature bases 0,64,128.
3. Hold eng_all_done off for 500 cycles in WAIT_DONE -> weights unchanged, no new fm reads; then pulse done -> NEXT the following cycle.
4. Assert rst mid-STREAM at pixel 20 -> all outputs 0 immediately, no layer_done; a new layer_start restarts from (0,0), address 0.
5. Pulse layer_start during STREAM, and eng_all_done during LOAD_W -> both ignored; channel sequence unchanged.
6. With CONV_SEQ_PERF_EN, IN_CH=OUT_CH=1, MAPSIZE=8, done 10 cycles after the last valid -> layer_cycles equals the measured start-to-done count (26+1+64+1+10+NEXT+DONE) and holds until the next start.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the conv layer sequencer and the 5x5 engine: FSM state,
// kernel geometry and the weight-window type that connects them.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        START,
        STREAM,
        WAIT_DONE,
        NEXT,
        DONE
    } seq_state_t;

    localparam int KWIN  = 5;
    localparam int KTAPS = KWIN * KWIN;

    typedef logic signed [7:0] wt_t;
    typedef wt_t [KWIN-1:0][KWIN-1:0] weight_win_t;

endpackage

// File: rtl/conv_weight_loader.sv
// Walks the 25 weight-ROM addresses of one kernel and captures the returned
// taps (1-cycle ROM latency) into a held bank; done fires on the last capture.
module conv_weight_loader
    import conv_pkg::*;
#(
    parameter int AW = 5
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [AW-1:0]     base,
    output logic [AW-1:0]     rd_addr,
    input  logic signed [7:0] rd_data,
    output weight_win_t       bank,
    output logic              done
);

    localparam int CW = $clog2(KTAPS + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    weight_win_t      bank_q, bank_d;
    logic [KTAPS-1:0] tap_we;

    // Count value gi+1 means the address for tap gi went out last cycle.
    generate
        for (genvar gi = 0; gi < KTAPS; gi++) begin : g_tap
            assign tap_we[gi] = active && (cnt_q == CW'(gi + 1));
        end
    endgenerate

    always_comb begin
        cnt_d  = active ? cnt_q + CW'(1) : '0;
        bank_d = bank_q;
        for (int r = 0; r < KWIN; r++) begin
            for (int c = 0; c < KWIN; c++) begin
                if (tap_we[r*KWIN + c]) begin
                    bank_d[r][c] = rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            bank_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bank_q <= bank_d;
        end
    end

    assign rd_addr = (active && cnt_q < CW'(KTAPS)) ? base + AW'(cnt_q) : '0;
    assign done    = active && (cnt_q == CW'(KTAPS));
    assign bank    = bank_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one conv layer: per (oc, ic) pair load weights, start the engine, stream
// one input plane, wait for the engine. Define CONV_SEQ_PERF_EN for layer_cycles.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int MAPSIZE = 32,
    parameter int IN_CH   = 6,
    parameter int OUT_CH  = 16,
    localparam int NPIX = MAPSIZE * MAPSIZE,
    localparam int WAW  = $clog2(OUT_CH * IN_CH * KTAPS),
    localparam int FAW  = $clog2(IN_CH * NPIX),
    localparam int OCW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int ICW  = (IN_CH > 1) ? $clog2(IN_CH) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    output logic              layer_busy,
    output logic              layer_done,
    output logic [WAW-1:0]    wt_rd_addr,
    input  logic signed [7:0] wt_rd_data,
    output weight_win_t       weights,
    output logic              fm_rd_en,
    output logic [FAW-1:0]    fm_rd_addr,
    input  logic signed [7:0] fm_rd_data,
    output logic              eng_start,
    output logic              eng_data_valid,
    output logic signed [7:0] eng_pixel,
    input  logic              eng_all_done,
    output logic [OCW-1:0]    oc_idx,
    output logic [ICW-1:0]    ic_idx,
    output logic              first_ic
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       layer_cycles
`endif
);

    localparam int PW = $clog2(NPIX + 1);

    seq_state_t     state_q, state_d;
    logic [OCW-1:0] oc_q, oc_d;
    logic [ICW-1:0] ic_q, ic_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           est_q, est_d;
    logic           fm_en_q, fm_en_d;
    logic [FAW-1:0] fm_addr_q, fm_addr_d;
    logic           dv_q, dv_d;
    logic           first_q, first_d;

    logic           ld_active;
    logic           ld_done;
    logic [WAW-1:0] ld_base;

    assign ld_active = (state_q == LOAD_W);
    assign ld_base   = WAW'((int'(oc_q) * IN_CH + int'(ic_q)) * KTAPS);

    conv_weight_loader #(
        .AW(WAW)
    ) u_loader (
        .clk     (clk),
        .rst     (rst),
        .active  (ld_active),
        .base    (ld_base),
        .rd_addr (wt_rd_addr),
        .rd_data (wt_rd_data),
        .bank    (weights),
        .done    (ld_done)
    );

    always_comb begin
        state_d = state_q;
        oc_d    = oc_q;
        ic_d    = ic_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: begin
                if (layer_start) begin
                    state_d = LOAD_W;
                    oc_d    = '0;
                    ic_d    = '0;
                end
            end
            LOAD_W: begin
                if (ld_done) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = STREAM;
                pix_d   = '0;
            end
            // Stay one extra cycle so the delayed valid burst completes here.
            STREAM: begin
                if (pix_q == PW'(NPIX)) begin
                    state_d = WAIT_DONE;
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
            WAIT_DONE: begin
                if (eng_all_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (int'(ic_q) < IN_CH - 1) begin
                    ic_d    = ic_q + ICW'(1);
                    state_d = LOAD_W;
                end else begin
                    ic_d = '0;
                    if (int'(oc_q) < OUT_CH - 1) begin
                        oc_d    = oc_q + OCW'(1);
                        state_d = LOAD_W;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        est_d     = (state_d == START);
        fm_en_d   = (state_d == STREAM) && (pix_d < PW'(NPIX));
        fm_addr_d = fm_en_d ? FAW'(int'(ic_d) * NPIX + int'(pix_d)) : '0;
        dv_d      = fm_en_q;
        first_d   = busy_d && (ic_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            oc_q      <= '0;
            ic_q      <= '0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            est_q     <= 1'b0;
            fm_en_q   <= 1'b0;
            fm_addr_q <= '0;
            dv_q      <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            ic_q      <= ic_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            est_q     <= est_d;
            fm_en_q   <= fm_en_d;
            fm_addr_q <= fm_addr_d;
            dv_q      <= dv_d;
            first_q   <= first_d;
        end
    end

    assign layer_busy     = busy_q;
    assign layer_done     = done_q;
    assign eng_start      = est_q;
    assign fm_rd_en       = fm_en_q;
    assign fm_rd_addr     = fm_addr_q;
    assign eng_data_valid = dv_q;
    assign eng_pixel      = fm_rd_data;
    assign oc_idx         = oc_q;
    assign ic_idx         = ic_q;
    assign first_ic       = first_q;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (state_q == IDLE && layer_start) begin
            cycles_d = '0;
        end else if (busy_q && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign layer_cycles = cycles_q;
`endif

endmodule
